// File: rtl/bus_decoder.sv
// Load/store port decoder: base/mask region decode with priority, per-region wait states,
// registered read-data steering and sticky capture of the first illegal access.
module bus_decoder #(
    parameter int unsigned                   NUM_REGIONS     = 4,
    parameter logic [32*NUM_REGIONS-1:0]     REGION_BASE     = {32'h2000_0000, 32'h1000_0000,
                                                                32'h0000_0400, 32'h0000_0000},
    parameter logic [32*NUM_REGIONS-1:0]     REGION_MASK     = {32'hFFFF_0000, 32'hFFFF_FFF0,
                                                                32'hFFFF_FF00, 32'hFFFF_FC00},
    parameter logic [4*NUM_REGIONS-1:0]      REGION_WAIT     = {4'd1, 4'd2, 4'd0, 4'd0},
    parameter logic [NUM_REGIONS-1:0]        REGION_WRITABLE = 4'b1110
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MemRead,
    input  logic                        MemWrite,
    input  logic [31:0]                 Addr,
    input  logic [32*NUM_REGIONS-1:0]   ReadDataIn,
    input  logic                        ErrClear,
    output logic [NUM_REGIONS-1:0]      CS,
    output logic [NUM_REGIONS-1:0]      WE,
    output logic                        Stall,
    output logic [31:0]                 ReadData,
    output logic                        BusErr,
    output logic [31:0]                 FaultAddr,
    output logic                        FaultWrite
);

    localparam int unsigned SelW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [SelW-1:0] cur_q;
    logic            wr_q;
    logic [SelW-1:0] rsel_q;
    logic            rvalid_q;
    logic            rzero_q;
    logic [31:0]     hold_q;

    logic            req;
    logic            any_hit;
    logic [SelW-1:0] sel;
    logic [3:0]      sel_wait;
    logic            sel_wr;
    logic            bad;
    logic            illegal;
    logic            done;
    logic            done_wr;
    logic [SelW-1:0] done_sel;

    // Descending scan so the lowest-index hit wins on overlap.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((Addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
                any_hit = 1'b1;
                sel     = SelW'(i);
            end
        end
    end

    assign req      = MemRead | MemWrite;
    assign sel_wait = REGION_WAIT[4*sel +: 4];
    assign sel_wr   = REGION_WRITABLE[sel];
    assign bad      = !any_hit || (MemWrite && !sel_wr);
    assign illegal  = !reset && (state_q == StIdle) && req && bad;

    always_comb begin
        CS       = '0;
        WE       = '0;
        Stall    = 1'b0;
        done     = 1'b0;
        done_wr  = 1'b0;
        done_sel = sel;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (req && !bad) begin
                        CS[sel] = 1'b1;
                        if (sel_wait == 4'd0) begin
                            WE[sel] = MemWrite;
                            done    = 1'b1;
                            done_wr = MemWrite;
                        end else begin
                            Stall = 1'b1;
                        end
                    end
                end
                StWait: begin
                    CS[cur_q] = 1'b1;
                    done_sel  = cur_q;
                    if (cnt_q != 4'd0) begin
                        Stall = 1'b1;
                    end else begin
                        WE[cur_q] = wr_q;
                        done      = 1'b1;
                        done_wr   = wr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (reset || rzero_q) begin
            ReadData = 32'h0;
        end else if (rvalid_q) begin
            ReadData = ReadDataIn[32*rsel_q +: 32];
        end else begin
            ReadData = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cur_q      <= '0;
            wr_q       <= 1'b0;
            rsel_q     <= '0;
            rvalid_q   <= 1'b0;
            rzero_q    <= 1'b0;
            hold_q     <= 32'h0;
            BusErr     <= 1'b0;
            FaultAddr  <= 32'h0;
            FaultWrite <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !bad && sel_wait != 4'd0) begin
                        cur_q   <= sel;
                        cnt_q   <= sel_wait - 4'd1;
                        wr_q    <= MemWrite;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Keep the last steered slice so ReadData holds once rvalid drops.
            if (rvalid_q) begin
                hold_q <= ReadDataIn[32*rsel_q +: 32];
            end
            rvalid_q <= done && !done_wr;
            rzero_q  <= illegal && MemRead;
            if (done && !done_wr) begin
                rsel_q <= done_sel;
            end

            if (illegal && (!BusErr || ErrClear)) begin
                BusErr     <= 1'b1;
                FaultAddr  <= Addr;
                FaultWrite <= MemWrite;
            end else if (ErrClear) begin
                BusErr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder with the default four-region map.
module tb_bus_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  Addr;
    logic [127:0] ReadDataIn;
    logic         ErrClear;
    logic [3:0]   CS;
    logic [3:0]   WE;
    logic         Stall;
    logic [31:0]  ReadData;
    logic         BusErr;
    logic [31:0]  FaultAddr;
    logic         FaultWrite;

    int nvec = 0;
    int nerr = 0;

    bus_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .ReadDataIn (ReadDataIn),
        .ErrClear   (ErrClear),
        .CS         (CS),
        .WE         (WE),
        .Stall      (Stall),
        .ReadData   (ReadData),
        .BusErr     (BusErr),
        .FaultAddr  (FaultAddr),
        .FaultWrite (FaultWrite)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] cs, input logic [3:0] we,
                           input logic st);
        chk({tag, ".CS"}, {28'h0, CS}, {28'h0, cs});
        chk({tag, ".WE"}, {28'h0, WE}, {28'h0, we});
        chk({tag, ".Stall"}, {31'h0, Stall}, {31'h0, st});
    endtask

    initial begin
        ReadDataIn = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_1111};
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Addr = 32'h400; ErrClear = 1'b0;
        tick();
        tick();
        chk_bus("reset", 4'b0000, 4'b0000, 1'b0);
        chk("reset.BusErr", {31'h0, BusErr}, 32'h0);
        chk("reset.ReadData", ReadData, 32'h0);
        chk("reset.FaultAddr", FaultAddr, 32'h0);

        // RAM store then load, zero wait states
        reset = 1'b0; MemWrite = 1'b1; Addr = 32'h404;
        #1 chk_bus("ram_st", 4'b0010, 4'b0010, 1'b0);
        tick();
        MemWrite = 1'b0; MemRead = 1'b1;
        #1 chk_bus("ram_ld", 4'b0010, 4'b0000, 1'b0);
        tick();
        MemRead = 1'b0;
        #1 chk_bus("idle", 4'b0000, 4'b0000, 1'b0);
        chk("ram_ld.ReadData", ReadData, 32'hCAFE_F00D);
        tick();

        // Two-wait-state load
        MemRead = 1'b1; Addr = 32'h1000_0008;
        #1 chk_bus("w2_ld.c1", 4'b0100, 4'b0000, 1'b1);
        tick();
        chk_bus("w2_ld.c2", 4'b0100, 4'b0000, 1'b1);
        tick();
        chk_bus("w2_ld.c3", 4'b0100, 4'b0000, 1'b0);
        tick();
        MemRead = 1'b0;
        #1 chk("w2_ld.ReadData", ReadData, 32'h2222_2222);
        chk_bus("w2_ld.after", 4'b0000, 4'b0000, 1'b0);
        tick();

        // Two-wait-state store: WE only on the final cycle
        MemWrite = 1'b1;
        #1 chk_bus("w2_st.c1", 4'b0100, 4'b0000, 1'b1);
        tick();
        chk_bus("w2_st.c2", 4'b0100, 4'b0000, 1'b1);
        tick();
        chk_bus("w2_st.c3", 4'b0100, 4'b0100, 1'b0);
        tick();

        // Store to ROM is illegal
        Addr = 32'h10;
        #1 chk_bus("rom_st", 4'b0000, 4'b0000, 1'b0);
        chk("rom_st.BusErr0", {31'h0, BusErr}, 32'h0);
        tick();
        MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h8000_0000;
        #1 chk("rom_st.BusErr", {31'h0, BusErr}, 32'h1);
        chk("rom_st.FaultAddr", FaultAddr, 32'h10);
        chk("rom_st.FaultWrite", {31'h0, FaultWrite}, 32'h1);
        chk_bus("unmapped_ld", 4'b0000, 4'b0000, 1'b0);
        tick();
        MemRead = 1'b0;
        #1 chk("unmapped_ld.FaultAddr", FaultAddr, 32'h10);
        chk("unmapped_ld.ReadData", ReadData, 32'h0);
        tick();
        chk("hold.ReadData", ReadData, 32'h2222_2222);

        // ErrClear alone
        ErrClear = 1'b1;
        tick();
        ErrClear = 1'b0;
        #1 chk("clr.BusErr", {31'h0, BusErr}, 32'h0);
        MemWrite = 1'b1; Addr = 32'h20;
        tick();
        MemWrite = 1'b0;
        #1 chk("rom_st2.FaultAddr", FaultAddr, 32'h20);

        // ErrClear together with a new fault
        ErrClear = 1'b1; MemRead = 1'b1; Addr = 32'h5000;
        tick();
        ErrClear = 1'b0; MemRead = 1'b0;
        #1 chk("clr_fault.BusErr", {31'h0, BusErr}, 32'h1);
        chk("clr_fault.FaultAddr", FaultAddr, 32'h5000);
        chk("clr_fault.FaultWrite", {31'h0, FaultWrite}, 32'h0);
        chk("clr_fault.ReadData", ReadData, 32'h0);
        tick();

        // Reset in cycle 2 of a two-wait-state store
        MemWrite = 1'b1; Addr = 32'h1000_0008;
        #1 chk_bus("rst_wait.c1", 4'b0100, 4'b0000, 1'b1);
        tick();
        reset = 1'b1;
        #1 chk_bus("rst_wait.c2", 4'b0000, 4'b0000, 1'b0);
        tick();
        reset = 1'b0; MemWrite = 1'b0;
        #1 chk_bus("rst_wait.idle", 4'b0000, 4'b0000, 1'b0);
        chk("rst_wait.BusErr", {31'h0, BusErr}, 32'h0);
        tick();
        MemRead = 1'b1; Addr = 32'h404;
        #1 chk_bus("rst_wait.ram_ld", 4'b0010, 4'b0000, 1'b0);
        tick();

        // One-wait-state region
        Addr = 32'h2000_1234;
        #1 chk("w1.ReadData", ReadData, 32'hCAFE_F00D);
        chk_bus("w1.c1", 4'b1000, 4'b0000, 1'b1);
        tick();
        chk_bus("w1.c2", 4'b1000, 4'b0000, 1'b0);
        tick();
        MemRead = 1'b0;
        #1 chk("w1.ReadData2", ReadData, 32'h3333_3333);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
